// File: rtl/riscv_wb_arbiter.sv
// Write-back arbiter in front of the register file: port A passes EX results through,
// port B serves LSU loads first and drains buffered MDU results in LSU-idle cycles.
module riscv_wb_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ex_valid_i,
  input  logic [ADDR_WIDTH-1:0] ex_waddr_i,
  input  logic [DATA_WIDTH-1:0] ex_wdata_i,
  input  logic                  lsu_valid_i,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
  input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
  input  logic                  mdu_valid_i,
  output logic                  mdu_ready_o,
  input  logic [ADDR_WIDTH-1:0] mdu_waddr_i,
  input  logic [DATA_WIDTH-1:0] mdu_wdata_i,
  input  logic [ADDR_WIDTH-1:0] raddr_a_i,
  input  logic [ADDR_WIDTH-1:0] raddr_b_i,
  input  logic [ADDR_WIDTH-1:0] raddr_c_i,
  output logic                  hazard_o,
  output logic                  we_a_o,
  output logic [ADDR_WIDTH-1:0] waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_b_o,
  output logic [ADDR_WIDTH-1:0] waddr_b_o,
  output logic [DATA_WIDTH-1:0] wdata_b_o
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  // MDU handshake: a result transfers in any cycle where mdu_valid_i & mdu_ready_o.
  logic [ADDR_WIDTH-1:0] waddr_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] wdata_mem_q [FIFO_DEPTH];
  logic                  valid_q     [FIFO_DEPTH];
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;

  always_comb begin
    we_a_o    = 1'b0;
    waddr_a_o = '0;
    wdata_a_o = '0;
    if (!rst) begin
      we_a_o    = ex_valid_i & (ex_waddr_i != '0);
      waddr_a_o = ex_waddr_i;
      wdata_a_o = ex_wdata_i;
    end
  end

  // Ready looks only at occupancy; a same-cycle pop does not open a slot.
  assign mdu_ready_o = !rst && (count_q < FULL);
  assign push        = mdu_valid_i & mdu_ready_o & (mdu_waddr_i != '0);

  always_comb begin
    pop       = 1'b0;
    we_b_o    = 1'b0;
    waddr_b_o = '0;
    wdata_b_o = '0;
    if (!rst) begin
      if (lsu_valid_i) begin
        we_b_o    = (lsu_waddr_i != '0);
        waddr_b_o = lsu_waddr_i;
        wdata_b_o = lsu_wdata_i;
      end else if (count_q != '0) begin
        we_b_o    = 1'b1;
        waddr_b_o = waddr_mem_q[rd_ptr_q];
        wdata_b_o = wdata_mem_q[rd_ptr_q];
        pop       = 1'b1;
      end
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
    if (push) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // The head entry still flags a hazard in the cycle it is written back.
  always_comb begin
    hazard_o = 1'b0;
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        if (valid_q[i]) begin
          if ((raddr_a_i != '0) && (raddr_a_i == waddr_mem_q[i])) hazard_o = 1'b1;
          if ((raddr_b_i != '0) && (raddr_b_i == waddr_mem_q[i])) hazard_o = 1'b1;
          if ((raddr_c_i != '0) && (raddr_c_i == waddr_mem_q[i])) hazard_o = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        valid_q[i]     <= 1'b0;
        waddr_mem_q[i] <= '0;
        wdata_mem_q[i] <= '0;
      end
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      if (pop) valid_q[rd_ptr_q] <= 1'b0;
      if (push) begin
        valid_q[wr_ptr_q]     <= 1'b1;
        waddr_mem_q[wr_ptr_q] <= mdu_waddr_i;
        wdata_mem_q[wr_ptr_q] <= mdu_wdata_i;
      end
    end
  end

endmodule

// File: tb/tb_riscv_wb_arbiter.sv
// Directed bench for riscv_wb_arbiter: a queue model of the MDU buffer is checked every
// negedge, alongside hand-computed literal expectations for each scenario.
module tb_riscv_wb_arbiter;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid_i, lsu_valid_i, mdu_valid_i;
  logic [AW-1:0] ex_waddr_i, lsu_waddr_i, mdu_waddr_i;
  logic [DW-1:0] ex_wdata_i, lsu_wdata_i, mdu_wdata_i;
  logic [AW-1:0] raddr_a_i, raddr_b_i, raddr_c_i;
  logic          mdu_ready_o, hazard_o, we_a_o, we_b_o;
  logic [AW-1:0] waddr_a_o, waddr_b_o;
  logic [DW-1:0] wdata_a_o, wdata_b_o;

  int total = 0;
  int bad   = 0;

  // Pending MDU results in drain order, each {waddr, wdata}.
  logic [AW+DW-1:0] exp_q[$];

  riscv_wb_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .ex_valid_i(ex_valid_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i),
    .lsu_valid_i(lsu_valid_i), .lsu_waddr_i(lsu_waddr_i), .lsu_wdata_i(lsu_wdata_i),
    .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
    .mdu_waddr_i(mdu_waddr_i), .mdu_wdata_i(mdu_wdata_i),
    .raddr_a_i(raddr_a_i), .raddr_b_i(raddr_b_i), .raddr_c_i(raddr_c_i),
    .hazard_o(hazard_o),
    .we_a_o(we_a_o), .waddr_a_o(waddr_a_o), .wdata_a_o(wdata_a_o),
    .we_b_o(we_b_o), .waddr_b_o(waddr_b_o), .wdata_b_o(wdata_b_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- model update ----------------
  always @(posedge clk or posedge rst) begin
    int n;
    if (rst) begin
      exp_q.delete();
    end else begin
      n = exp_q.size();
      if (!lsu_valid_i && n > 0) void'(exp_q.pop_front());
      if (mdu_valid_i && n < DEPTH && mdu_waddr_i != 0) exp_q.push_back({mdu_waddr_i, mdu_wdata_i});
    end
  end

  // ---------------- compare ----------------
  always @(negedge clk) begin
    logic          e_we_b, e_haz;
    logic [AW-1:0] e_ab, ea;
    logic [DW-1:0] e_db;
    if (rst) begin
      chk("rst_we_a", we_a_o, 0);
      chk("rst_we_b", we_b_o, 0);
      chk("rst_hazard", hazard_o, 0);
      chk("rst_ready", mdu_ready_o, 0);
      chk("rst_waddr_a", waddr_a_o, 0);
      chk("rst_wdata_a", wdata_a_o, 0);
      chk("rst_waddr_b", waddr_b_o, 0);
      chk("rst_wdata_b", wdata_b_o, 0);
    end else begin
      chk("m_we_a", we_a_o, ex_valid_i && ex_waddr_i != 0);
      chk("m_waddr_a", waddr_a_o, ex_waddr_i);
      chk("m_wdata_a", wdata_a_o, ex_wdata_i);
      chk("m_ready", mdu_ready_o, exp_q.size() < DEPTH);
      e_we_b = 1'b0; e_ab = '0; e_db = '0;
      if (lsu_valid_i) begin
        e_we_b = (lsu_waddr_i != 0); e_ab = lsu_waddr_i; e_db = lsu_wdata_i;
      end else if (exp_q.size() > 0) begin
        e_we_b = 1'b1; {e_ab, e_db} = exp_q[0];
      end
      chk("m_we_b", we_b_o, e_we_b);
      if (e_we_b) begin
        chk("m_waddr_b", waddr_b_o, e_ab);
        chk("m_wdata_b", wdata_b_o, e_db);
      end
      e_haz = 1'b0;
      foreach (exp_q[i]) begin
        ea = exp_q[i][AW+DW-1:DW];
        if ((raddr_a_i != 0 && raddr_a_i == ea) || (raddr_b_i != 0 && raddr_b_i == ea) ||
            (raddr_c_i != 0 && raddr_c_i == ea)) e_haz = 1'b1;
      end
      chk("m_hazard", hazard_o, e_haz);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    ex_valid_i = 0; ex_waddr_i = 0; ex_wdata_i = 0;
    lsu_valid_i = 0; lsu_waddr_i = 0; lsu_wdata_i = 0;
    mdu_valid_i = 0; mdu_waddr_i = 0; mdu_wdata_i = 0;
    raddr_a_i = 0; raddr_b_i = 0; raddr_c_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mdu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    mdu_valid_i = 1; mdu_waddr_i = a; mdu_wdata_i = d;
  endtask

  task automatic lsu(input logic [AW-1:0] a, input logic [DW-1:0] d);
    lsu_valid_i = 1; lsu_waddr_i = a; lsu_wdata_i = d;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [AW-1:0] nxt;
    logic          acc;
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_we_b", we_b_o, 0);
    chk("reset_ready", mdu_ready_o, 0);

    // EX pass-through, including x0
    rst = 1'b0;
    ex_valid_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'h1234;
    #1;
    chk("t1_we_a", we_a_o, 1);
    chk("t1_waddr_a", waddr_a_o, 5);
    chk("t1_wdata_a", wdata_a_o, 32'h1234);
    step();
    ex_waddr_i = 0;
    #1;
    chk("t1_we_a_x0", we_a_o, 0);

    // MDU single result, one-cycle latency
    step(); idle(); mdu(7, 32'hAA);
    #1;
    chk("t2_ready", mdu_ready_o, 1);
    chk("t2_we_b_same", we_b_o, 0);
    step(); idle();
    #1;
    chk("t2_we_b", we_b_o, 1);
    chk("t2_waddr_b", waddr_b_o, 7);
    chk("t2_wdata_b", wdata_b_o, 32'hAA);
    step();
    #1;
    chk("t2_empty", we_b_o, 0);

    // LSU busy 4 cycles, three MDU offers
    step(); idle(); lsu(3, 32'h300); mdu(11, 32'h111);
    #1;
    chk("t3_lsu_addr", waddr_b_o, 3);
    step(); lsu(3, 32'h301); mdu(12, 32'h222);
    step(); lsu(3, 32'h302); mdu(13, 32'h333);
    #1;
    chk("t3_ready_full", mdu_ready_o, 0);
    step(); lsu(3, 32'h303);
    #1;
    chk("t3_ready_full2", mdu_ready_o, 0);
    step(); idle();
    #1;
    chk("t3_drain0", waddr_b_o, 11);
    chk("t3_drain0_d", wdata_b_o, 32'h111);
    step();
    #1;
    chk("t3_drain1", waddr_b_o, 12);
    step();
    #1;
    chk("t3_done", we_b_o, 0);

    // Hazard on a buffered x9; LSU to x0 still blocks the drain
    step(); idle(); lsu(0, 32'h5); mdu(9, 32'h99);
    step(); mdu_valid_i = 0; raddr_b_i = 9;
    #1;
    chk("t4_haz_b", hazard_o, 1);
    chk("t4_lsu_x0_we_b", we_b_o, 0);
    step(); raddr_b_i = 0;
    #1;
    chk("t4_haz_zero", hazard_o, 0);
    step(); raddr_b_i = 10; raddr_c_i = 9;
    #1;
    chk("t4_haz_c", hazard_o, 1);
    raddr_c_i = 0;
    #1;
    chk("t4_haz_ten", hazard_o, 0);
    step(); lsu_valid_i = 0; raddr_b_i = 9;
    #1;
    chk("t4_haz_popcyc", hazard_o, 1);
    chk("t4_drain_x9", waddr_b_o, 9);
    step();
    #1;
    chk("t4_haz_clear", hazard_o, 0);

    // MDU result to x0 is accepted but never written
    step(); idle(); mdu(0, 32'hDEAD);
    #1;
    chk("t4_x0_ready", mdu_ready_o, 1);
    step(); idle();
    #1;
    chk("t4_x0_discard", we_b_o, 0);

    // Full FIFO with MDU held: pushes and pops overlap across pointer wrap
    step(); idle(); lsu(1, 32'h1); mdu(14, 32'h140);
    step(); mdu(15, 32'h150);
    nxt = 16;
    for (int k = 0; k < 8; k++) begin
      step(); lsu_valid_i = 0; mdu(nxt, {nxt, 4'h0});
      #1;
      if (k == 0) chk("t5_head14", waddr_b_o, 14);
      if (k == 1) chk("t5_head15", waddr_b_o, 15);
      if (k == 2) chk("t5_head16", waddr_b_o, 16);
      acc = mdu_ready_o;
      if (acc) nxt = nxt + 1;
    end
    step(); idle();
    repeat (3) step();
    #1;
    chk("t5_drained", we_b_o, 0);

    // Reset with two entries pending
    step(); idle(); lsu(2, 32'h2); mdu(20, 32'h200);
    step(); mdu(21, 32'h210);
    step(); idle();
    #1;
    chk("t6_pending", we_b_o, 1);
    rst = 1'b1;
    #1;
    chk("t6_rst_we_b", we_b_o, 0);
    chk("t6_rst_ready", mdu_ready_o, 0);
    step(); step();
    rst = 1'b0;
    #1;
    chk("t6_post_ready", mdu_ready_o, 1);
    chk("t6_post_we_b", we_b_o, 0);
    step();
    #1;
    chk("t6_no_stale", we_b_o, 0);
    repeat (2) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
